icache_ctrl: RTL and testbench

- Direct-mapped instruction cache that sits between the PC/fetch stage and instruction memory.
- It supplies INSTRUCTION to the IF/ID pipeline register and raises BUSY_WAIT to freeze PC and IF/ID on a miss.
- It is the responder side of the fetch handshake and the initiator toward the block-wide instruction memory.
- Hits return in the same cycle; misses refill a 128-bit block through a 3-state FSM.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_word_sel.sv | 16 +
 rtl/icache_ctrl.sv | 143 ++++++++++++++
 tb/tb_icache_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants for the direct-mapped instruction cache.
//   - FSM state encoding (IDLE, MEM_READ_ST, UPDATE)
//   - block geometry (16-byte blocks, 4 words)
//   - bit positions used to split a fetch address into offset/index/tag
package icache_pkg;

   // FSM encoding, kept as plain 2-bit constants for legacy compatibility
   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] MEM_READ_ST = 2'd1;
   localparam logic [1:0] UPDATE      = 2'd2;

   localparam int BLOCK_BYTES     = 16;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int WORD_BITS       = 32;
   localparam int BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;

   // Address split: [1:0] byte-in-word (ignored), [3:2] word offset,
   // index starts at bit 4, tag sits above the index.
   localparam int OFFSET_LSB  = 2;
   localparam int OFFSET_MSB  = 3;
   localparam int OFFSET_BITS = OFFSET_MSB - OFFSET_LSB + 1;
   localparam int INDEX_LSB   = 4;

endpackage

// File: rtl/icache_word_sel.sv
// icache_word_sel: picks one 32-bit word out of a 128-bit cache block.
// Ports:
//   block_i  [127:0]  cache block, word w at bits [32w+31:32w]
//   offset_i [1:0]    word offset within the block
//   word_o   [31:0]   selected word
module icache_word_sel
   import icache_pkg::*;
(
   input  logic [BLOCK_BITS-1:0]  block_i,
   input  logic [OFFSET_BITS-1:0] offset_i,
   output logic [WORD_BITS-1:0]   word_o
);

   assign word_o = block_i[offset_i*WORD_BITS +: WORD_BITS];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache between the fetch
// stage and a block-wide instruction memory. Hits are answered in the same
// cycle; a miss stalls the CPU through BUSY_WAIT while a 128-bit block is
// refilled (IDLE -> MEM_READ_ST -> UPDATE -> IDLE).
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   ADDRESS[31:0], READ   fetch request from the PC stage
//   INSTRUCTION[31:0]     fetched word (valid when READ && !BUSY_WAIT)
//   BUSY_WAIT             stall to PC and IF/ID register
//   MEM_ADDRESS[27:0]     block address toward instruction memory
//   MEM_READ              block read request
//   MEM_READDATA[127:0]   refill block
//   MEM_BUSYWAIT          memory busy; data valid on first low cycle
//   HIT_COUNT, MISS_COUNT 32-bit statistics (only with ICACHE_STATS_EN)
// Optional feature macro: ICACHE_STATS_EN
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 32 - 4 - INDEX_BITS
)(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [31:0]             ADDRESS,
   input  logic                    READ,
   output logic [31:0]             INSTRUCTION,
   output logic                    BUSY_WAIT,
   output logic [27:0]             MEM_ADDRESS,
   output logic                    MEM_READ,
   input  logic [BLOCK_BITS-1:0]   MEM_READDATA,
`ifdef ICACHE_STATS_EN
   input  logic                    MEM_BUSYWAIT,
   output logic [31:0]             HIT_COUNT,
   output logic [31:0]             MISS_COUNT
`else
   input  logic                    MEM_BUSYWAIT
`endif
);

   localparam int NBLK = 1 << INDEX_BITS;

   // Address decode
   logic [OFFSET_BITS-1:0] offset;
   logic [INDEX_BITS-1:0]  index;
   logic [TAG_BITS-1:0]    tag;
   logic [1:0]             unused_addr_bits;

   assign offset           = ADDRESS[OFFSET_MSB:OFFSET_LSB];
   assign index            = ADDRESS[INDEX_LSB+INDEX_BITS-1:INDEX_LSB];
   assign tag              = ADDRESS[31:INDEX_LSB+INDEX_BITS];
   assign unused_addr_bits = ADDRESS[1:0];

   // Storage: only the valid bits are reset
   logic [BLOCK_BITS-1:0] data_q [NBLK];
   logic [TAG_BITS-1:0]   tag_q  [NBLK];
   logic [NBLK-1:0]       valid_q;

   // Refill bookkeeping: address latched on entry to MEM_READ_ST, block
   // captured on the edge memory completes
   logic [TAG_BITS-1:0]   ref_tag_q;
   logic [INDEX_BITS-1:0] ref_idx_q;
   logic [BLOCK_BITS-1:0] blk_q;

   logic [1:0] state_q, state_d;

   logic hit, miss_start, mem_done;
   logic [WORD_BITS-1:0] sel_word;

   assign hit        = valid_q[index] && (tag_q[index] == tag);
   assign miss_start = (state_q == IDLE) && READ && !hit;
   assign mem_done   = (state_q == MEM_READ_ST) && !MEM_BUSYWAIT;

   icache_word_sel u_word_sel (
      .block_i  (data_q[index]),
      .offset_i (offset),
      .word_o   (sel_word)
   );

   assign INSTRUCTION = hit ? sel_word : 32'h0000_0000;
   // Combinational so the pipeline freezes in the very cycle of the miss
   assign BUSY_WAIT   = (state_q != IDLE) || (READ && !hit);
   assign MEM_READ    = (state_q == MEM_READ_ST);
   assign MEM_ADDRESS = MEM_READ ? {ref_tag_q, ref_idx_q} : 28'h0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (READ && !hit) state_d = MEM_READ_ST;
         MEM_READ_ST: if (!MEM_BUSYWAIT) state_d = UPDATE;
         UPDATE:      state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         ref_tag_q <= '0;
         ref_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (miss_start) begin
            ref_tag_q <= tag;
            ref_idx_q <= index;
         end
         if (state_q == UPDATE) valid_q[ref_idx_q] <= 1'b1;
      end
   end

   // Data/tag arrays are not reset; a block written during a reset edge
   // is harmless because its valid bit stays clear.
   always_ff @(posedge CLK) begin
      if (mem_done) blk_q <= MEM_READDATA;
      if (state_q == UPDATE) begin
         data_q[ref_idx_q] <= blk_q;
         tag_q[ref_idx_q]  <= ref_tag_q;
      end
   end

`ifdef ICACHE_STATS_EN
   logic        after_upd_q;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         after_upd_q <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         after_upd_q <= (state_q == UPDATE);
         if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
         // The access that completes a refill is not a hit
         if ((state_q == IDLE) && READ && hit && !after_upd_q)
            hit_cnt_q <= hit_cnt_q + 32'd1;
      end
   end

   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  ADDRESS;
   logic         READ;
   logic [31:0]  INSTRUCTION;
   logic         BUSY_WAIT;
   logic [27:0]  MEM_ADDRESS;
   logic         MEM_READ;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
   logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int mr_cycles = 0;
   int mcnt = 0;

   always #5 CLK = ~CLK;

   icache_ctrl dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ADDRESS      (ADDRESS),
      .READ         (READ),
      .INSTRUCTION  (INSTRUCTION),
      .BUSY_WAIT    (BUSY_WAIT),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READ     (MEM_READ),
      .MEM_READDATA (MEM_READDATA),
`ifdef ICACHE_STATS_EN
      .MEM_BUSYWAIT (MEM_BUSYWAIT),
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT)
`else
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
`endif
   );

   // Memory model: word w of block b is (b<<8) + 0x11*(w+1); busy for the
   // first 4 cycles of a request, data on the 5th.
   function automatic logic [127:0] blk_of(input logic [27:0] b);
      logic [127:0] r;
      logic [31:0]  bb;
      bb = {4'h0, b};
      for (int w = 0; w < 4; w++) r[32*w +: 32] = (bb << 8) + 32'h11 * (w + 1);
      return r;
   endfunction

   assign MEM_READDATA = blk_of(MEM_ADDRESS);
   assign MEM_BUSYWAIT = !(MEM_READ && mcnt == 4);

   always @(posedge CLK) begin
      if (!MEM_READ) mcnt <= 0;
      else if (MEM_BUSYWAIT) mcnt <= mcnt + 1;
      if (MEM_READ) mr_cycles <= mr_cycles + 1;
   end

   task automatic tick;
      @(posedge CLK); #1;
   endtask

   // Counts remaining stall cycles until BUSY_WAIT drops; returns at the
   // negedge where BUSY_WAIT is low.
   task automatic run_stall(output int stall);
      stall = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (!BUSY_WAIT) return;
         stall++;
         tick();
      end
      n_total++;
      $display("FAIL refill_timeout: BUSY_WAIT still high after 50 cycles, required low");
   endtask

   task automatic test_reset;
      RESET = 1'b1; READ = 1'b0; ADDRESS = 32'h0;
      tick(); tick();
      RESET = 1'b0;
      @(negedge CLK);
      n_total++;
      if (BUSY_WAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 28'h0)
         $display("FAIL reset_outputs: bw=%b mr=%b ma=%h, required 0 0 0", BUSY_WAIT, MEM_READ, MEM_ADDRESS);
      else n_pass++;
`ifdef ICACHE_STATS_EN
      n_total++;
      if (HIT_COUNT !== 32'd0 || MISS_COUNT !== 32'd0)
         $display("FAIL reset_stats: hit=%0d miss=%0d, required 0 0", HIT_COUNT, MISS_COUNT);
      else n_pass++;
`endif
      tick();
   endtask

   task automatic test_cold_miss;
      int s;
      READ = 1'b1; ADDRESS = 32'h0;
      @(negedge CLK);
      n_total++;
      if (BUSY_WAIT !== 1'b1 || MEM_READ !== 1'b0)
         $display("FAIL cold_detect: bw=%b mr=%b, required 1 0", BUSY_WAIT, MEM_READ);
      else n_pass++;
      tick();
      @(negedge CLK);
      n_total++;
      if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h0)
         $display("FAIL cold_memreq: mr=%b ma=%h, required 1 0000000", MEM_READ, MEM_ADDRESS);
      else n_pass++;
      tick();
      run_stall(s);
      n_total++;
      if (s + 2 !== 7) $display("FAIL cold_stall: got %0d cycles, required 7", s + 2);
      else n_pass++;
      n_total++;
      if (INSTRUCTION !== 32'h11) $display("FAIL cold_instr: got %h, required 00000011", INSTRUCTION);
      else n_pass++;
      tick();
   endtask

   task automatic test_hits;
      logic [31:0] addrs [3];
      logic [31:0] exp   [3];
      int mr0;
      addrs = '{32'h4, 32'h8, 32'hC};
      exp   = '{32'h22, 32'h33, 32'h44};
      mr0 = mr_cycles;
      for (int i = 0; i < 3; i++) begin
         ADDRESS = addrs[i];
         @(negedge CLK);
         n_total++;
         if (INSTRUCTION !== exp[i] || BUSY_WAIT !== 1'b0 || MEM_READ !== 1'b0)
            $display("FAIL hit_%0d: instr=%h bw=%b mr=%b, required %h 0 0", i, INSTRUCTION, BUSY_WAIT, MEM_READ, exp[i]);
         else n_pass++;
         tick();
      end
      n_total++;
      if (mr_cycles !== mr0) $display("FAIL hits_no_memread: %0d MEM_READ cycles, required 0", mr_cycles - mr0);
      else n_pass++;
   endtask

   task automatic test_conflict;
      int s;
      ADDRESS = 32'h80;
      @(negedge CLK);
      n_total++;
      if (BUSY_WAIT !== 1'b1 || INSTRUCTION !== 32'h0)
         $display("FAIL conflict_detect: bw=%b instr=%h, required 1 00000000", BUSY_WAIT, INSTRUCTION);
      else n_pass++;
      tick();
      @(negedge CLK);
      n_total++;
      if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h8)
         $display("FAIL conflict_memreq: mr=%b ma=%h, required 1 0000008", MEM_READ, MEM_ADDRESS);
      else n_pass++;
      tick();
      run_stall(s);
      n_total++;
      if (s + 2 !== 7 || INSTRUCTION !== 32'h811)
         $display("FAIL conflict_fill: stall=%0d instr=%h, required 7 00000811", s + 2, INSTRUCTION);
      else n_pass++;
`ifdef ICACHE_STATS_EN
      n_total++;
      if (MISS_COUNT !== 32'd2 || HIT_COUNT !== 32'd3)
         $display("FAIL stats: miss=%0d hit=%0d, required 2 3", MISS_COUNT, HIT_COUNT);
      else n_pass++;
`endif
      tick();
      ADDRESS = 32'h0;
      @(negedge CLK);
      n_total++;
      if (BUSY_WAIT !== 1'b1) $display("FAIL conflict_evict: bw=%b, required 1", BUSY_WAIT);
      else n_pass++;
      tick();
      run_stall(s);
      n_total++;
      if (s + 1 !== 7 || INSTRUCTION !== 32'h11)
         $display("FAIL conflict_refill0: stall=%0d instr=%h, required 7 00000011", s + 1, INSTRUCTION);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_refill;
      int s;
      ADDRESS = 32'h200;
      tick();
      @(negedge CLK);
      n_total++;
      if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h20)
         $display("FAIL midrst_memreq: mr=%b ma=%h, required 1 0000020", MEM_READ, MEM_ADDRESS);
      else n_pass++;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      n_total++;
      if (MEM_READ !== 1'b0 || MEM_ADDRESS !== 28'h0 || BUSY_WAIT !== 1'b1)
         $display("FAIL midrst_idle: mr=%b ma=%h bw=%b, required 0 0000000 1", MEM_READ, MEM_ADDRESS, BUSY_WAIT);
      else n_pass++;
      tick();
      run_stall(s);
      n_total++;
      if (s + 1 !== 7 || INSTRUCTION !== 32'h2011)
         $display("FAIL midrst_refill: stall=%0d instr=%h, required 7 00002011", s + 1, INSTRUCTION);
      else n_pass++;
      tick();
   endtask

   task automatic test_read_low;
      int bad;
      bad = 0;
      READ = 1'b0; ADDRESS = 32'h100;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (BUSY_WAIT !== 1'b0 || MEM_READ !== 1'b0 || INSTRUCTION !== 32'h0) bad++;
         tick();
      end
      n_total++;
      if (bad !== 0) $display("FAIL read_low: %0d cycles with stall/request/data, required 0", bad);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hits();
      test_conflict();
      test_reset_mid_refill();
      test_read_low();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
